// File: rtl/func_response_checker_pkg.sv
// Shared types and constants for the func response checker.
package func_chk_pkg;

  localparam int unsigned VEC_W = 5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } chk_state_t;

endpackage

// File: rtl/func_response_checker_if.sv
// Stimulus/response handshake between the DUT output sampler and the checker.
interface func_response_checker_if;
  import func_chk_pkg::*;

  logic             vec_valid;
  logic             vec_ready;
  logic [VEC_W-1:0] vec_in;
  logic             y_obs;

  modport master (
    output vec_valid,
    output vec_in,
    output y_obs,
    input  vec_ready
  );

  modport slave (
    input  vec_valid,
    input  vec_in,
    input  y_obs,
    output vec_ready
  );
endinterface

// File: rtl/func_response_checker_sat_counter.sv
// Saturating incrementer with synchronous clear; holds at all-ones.
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  // Clear wins over increment; increment stops at the maximum value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      count <= '0;
    else if (clr)
      count <= '0;
    else if (inc && (count != '1))
      count <= count + W'(1);
  end

endmodule

// File: rtl/func_response_checker.sv
// Compares observed DUT responses against a golden 5-input truth table,
// counting vectors and mismatches and capturing the first failing vector.
module func_response_checker
  import func_chk_pkg::*;
#(
  parameter logic [31:0] EXPECT_TT = 32'h8000_0001,
  parameter int unsigned NUM_VEC   = 7,
  parameter int unsigned CNT_W     = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  func_response_checker_if.slave  chk,
  output logic                    busy,
  output logic                    done,
  output logic                    pass,
  output logic [CNT_W-1:0]        vec_count,
  output logic [CNT_W-1:0]        err_count,
  output logic                    first_fail_valid,
  output logic [VEC_W-1:0]        first_fail_vec
);

  localparam int unsigned RUN_W = $clog2(NUM_VEC + 1);
  localparam logic [RUN_W-1:0] LAST_IDX = RUN_W'(NUM_VEC - 1);

  chk_state_t       state_q, state_d;
  logic [RUN_W-1:0] run_cnt;
  logic             ready;
  logic             accept;
  logic             start_go;
  logic             cmp_valid;
  logic             cmp_mis;
  logic [VEC_W-1:0] cmp_vec;

  assign accept = chk.vec_valid && ready;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state_q <= IDLE;
    else
      state_q <= state_d;
  end

  // Next-state logic; start only honoured from IDLE or DONE.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (accept && (run_cnt == LAST_IDX)) state_d = DRAIN;
      DRAIN:   state_d = DONE;
      DONE:    if (start) state_d = RUN;
      default: state_d = IDLE;
    endcase
  end

  // State-decoded outputs.
  always_comb begin
    ready    = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    start_go = 1'b0;
    unique case (state_q)
      IDLE:    start_go = start;
      RUN:     begin ready = 1'b1; busy = 1'b1; end
      DRAIN:   busy = 1'b1;
      DONE:    begin done = 1'b1; start_go = start; end
      default: ;
    endcase
  end

  assign chk.vec_ready = ready;
  assign pass          = done && (err_count == '0);

  // Run-length counter, sized for NUM_VEC rather than the reported width.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      run_cnt <= '0;
    else if (start_go)
      run_cnt <= '0;
    else if (accept)
      run_cnt <= run_cnt + RUN_W'(1);
  end

  // Compare stage: register the vector and its mismatch flag on accept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cmp_valid <= 1'b0;
      cmp_mis   <= 1'b0;
      cmp_vec   <= '0;
    end else begin
      cmp_valid <= accept;
      if (accept) begin
        cmp_vec <= chk.vec_in;
        cmp_mis <= chk.y_obs ^ EXPECT_TT[chk.vec_in];
      end
    end
  end

  // First-fail capture, sticky until the next run starts.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      first_fail_valid <= 1'b0;
      first_fail_vec   <= '0;
    end else if (start_go) begin
      first_fail_valid <= 1'b0;
      first_fail_vec   <= '0;
    end else if (cmp_valid && cmp_mis && !first_fail_valid) begin
      first_fail_valid <= 1'b1;
      first_fail_vec   <= cmp_vec;
    end
  end

  sat_counter #(.W(CNT_W)) u_vec_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (start_go),
    .inc   (cmp_valid),
    .count (vec_count)
  );

  sat_counter #(.W(CNT_W)) u_err_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (start_go),
    .inc   (cmp_valid && cmp_mis),
    .count (err_count)
  );

endmodule

// File: tb/tb_func_response_checker.sv
// Directed bench for func_response_checker: default instance plus a
// narrow-counter instance for saturation.
module tb_func_response_checker;
  import func_chk_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start0 = 1'b0;
  logic start1 = 1'b0;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  func_response_checker_if if0 ();
  func_response_checker_if if1 ();

  logic             busy0, done0, pass0, ffv0;
  logic [15:0]      vc0, ec0;
  logic [VEC_W-1:0] ffvec0;
  logic             busy1, done1, pass1, ffv1;
  logic [1:0]       vc1, ec1;
  logic [VEC_W-1:0] ffvec1;

  func_response_checker #(.EXPECT_TT(32'h8000_0001), .NUM_VEC(7), .CNT_W(16)) dut0 (
    .clk(clk), .rst(rst), .start(start0), .chk(if0.slave),
    .busy(busy0), .done(done0), .pass(pass0),
    .vec_count(vc0), .err_count(ec0),
    .first_fail_valid(ffv0), .first_fail_vec(ffvec0)
  );

  func_response_checker #(.EXPECT_TT(32'h8000_0001), .NUM_VEC(7), .CNT_W(2)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .chk(if1.slave),
    .busy(busy1), .done(done1), .pass(pass1),
    .vec_count(vc1), .err_count(ec1),
    .first_fail_valid(ffv1), .first_fail_vec(ffvec1)
  );

  logic [4:0] sweep_v [7] = '{5'b00000, 5'b10000, 5'b01000, 5'b00100,
                              5'b00010, 5'b00001, 5'b11111};
  logic       clean_y [7] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
  logic       bad_y   [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
  logic       wrong_y [7] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

  task automatic pulse_start0();
    @(negedge clk); start0 = 1'b1;
    @(posedge clk); #1; start0 = 1'b0;
  endtask

  task automatic send0(input logic [4:0] v, input logic y);
    @(negedge clk);
    if0.vec_valid = 1'b1; if0.vec_in = v; if0.y_obs = y;
    if (if0.vec_ready !== 1'b1) begin
      $display("FAIL send0_ready vec=%b got=%b want=1", v, if0.vec_ready); bad++;
    end
    total++;
    @(posedge clk); #1;
    if0.vec_valid = 1'b0;
  endtask

  task automatic send1(input logic [4:0] v, input logic y);
    @(negedge clk);
    if1.vec_valid = 1'b1; if1.vec_in = v; if1.y_obs = y;
    @(posedge clk); #1;
    if1.vec_valid = 1'b0;
  endtask

  task automatic wait_done0(input string tag);
    int n = 0;
    while (done0 !== 1'b1 && n < 20) begin
      @(posedge clk); #1; n++;
    end
    if (done0 !== 1'b1) begin
      $display("FAIL %s_timeout done=%b want=1", tag, done0); bad++;
    end
    total++;
  endtask

  task automatic test_reset();
    if0.vec_valid = 1'b0; if0.vec_in = '0; if0.y_obs = 1'b0;
    if1.vec_valid = 1'b0; if1.vec_in = '0; if1.y_obs = 1'b0;
    rst = 1'b1;
    #12;
    if ({busy0, done0, pass0, ffv0, if0.vec_ready} !== 5'b0 || vc0 !== 16'd0 || ec0 !== 16'd0 || ffvec0 !== 5'd0) begin
      $display("FAIL reset_outputs busy=%b done=%b pass=%b ffv=%b rdy=%b vc=%0d ec=%0d want all 0",
               busy0, done0, pass0, ffv0, if0.vec_ready, vc0, ec0); bad++;
    end
    total++;
    @(negedge clk); rst = 1'b0;
    if0.vec_valid = 1'b1; if0.vec_in = 5'b00100; if0.y_obs = 1'b1;
    repeat (3) @(posedge clk);
    #1; if0.vec_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    if (vc0 !== 16'd0 || ec0 !== 16'd0 || busy0 !== 1'b0) begin
      $display("FAIL idle_valid_ignored vc=%0d ec=%0d busy=%b want 0 0 0", vc0, ec0, busy0); bad++;
    end
    total++;
  endtask

  task automatic test_clean_sweep();
    pulse_start0();
    if (busy0 !== 1'b1 || if0.vec_ready !== 1'b1) begin
      $display("FAIL clean_busy busy=%b rdy=%b want 1 1", busy0, if0.vec_ready); bad++;
    end
    total++;
    for (int i = 0; i < 7; i++) send0(sweep_v[i], clean_y[i]);
    if (busy0 !== 1'b1 || done0 !== 1'b0 || if0.vec_ready !== 1'b0) begin
      $display("FAIL clean_drain busy=%b done=%b rdy=%b want 1 0 0", busy0, done0, if0.vec_ready); bad++;
    end
    total++;
    @(posedge clk); #1;
    if (done0 !== 1'b1 || busy0 !== 1'b0) begin
      $display("FAIL clean_done_edge done=%b busy=%b want 1 0", done0, busy0); bad++;
    end
    total++;
    if (vc0 !== 16'd7 || ec0 !== 16'd0 || pass0 !== 1'b1 || ffv0 !== 1'b0) begin
      $display("FAIL clean_result vc=%0d ec=%0d pass=%b ffv=%b want 7 0 1 0", vc0, ec0, pass0, ffv0); bad++;
    end
    total++;
  endtask

  task automatic test_mismatch();
    pulse_start0();
    for (int i = 0; i < 7; i++) send0(sweep_v[i], bad_y[i]);
    wait_done0("mismatch");
    if (vc0 !== 16'd7 || ec0 !== 16'd2 || pass0 !== 1'b0) begin
      $display("FAIL mismatch_counts vc=%0d ec=%0d pass=%b want 7 2 0", vc0, ec0, pass0); bad++;
    end
    total++;
    if (ffv0 !== 1'b1 || ffvec0 !== 5'b00100) begin
      $display("FAIL mismatch_first ffv=%b vec=%b want 1 00100", ffv0, ffvec0); bad++;
    end
    total++;
  endtask

  task automatic test_gaps_restart();
    pulse_start0();
    if (vc0 !== 16'd0 || ec0 !== 16'd0 || ffv0 !== 1'b0 || busy0 !== 1'b1 || done0 !== 1'b0) begin
      $display("FAIL restart_clear vc=%0d ec=%0d ffv=%b busy=%b done=%b want 0 0 0 1 0",
               vc0, ec0, ffv0, busy0, done0); bad++;
    end
    total++;
    for (int i = 0; i < 7; i++) begin
      int gap = $urandom_range(0, 3);
      repeat (gap) @(posedge clk);
      #1;
      send0(sweep_v[i], clean_y[i]);
      if (i == 2) begin
        pulse_start0();
        if (vc0 !== 16'd3 || busy0 !== 1'b1) begin
          $display("FAIL start_in_run vc=%0d busy=%b want 3 1", vc0, busy0); bad++;
        end
        total++;
      end
    end
    wait_done0("gaps");
    if (vc0 !== 16'd7 || pass0 !== 1'b1) begin
      $display("FAIL gaps_result vc=%0d pass=%b want 7 1", vc0, pass0); bad++;
    end
    total++;
  endtask

  task automatic test_saturation();
    @(negedge clk); start1 = 1'b1;
    @(posedge clk); #1; start1 = 1'b0;
    for (int i = 0; i < 6; i++) send1(sweep_v[i], wrong_y[i]);
    if (busy1 !== 1'b1 || if1.vec_ready !== 1'b1 || done1 !== 1'b0) begin
      $display("FAIL sat_after6 busy=%b rdy=%b done=%b want 1 1 0", busy1, if1.vec_ready, done1); bad++;
    end
    total++;
    send1(sweep_v[6], wrong_y[6]);
    @(posedge clk); #1;
    if (done1 !== 1'b1) begin
      $display("FAIL sat_done done=%b want 1", done1); bad++;
    end
    total++;
    if (vc1 !== 2'd3 || ec1 !== 2'd3 || pass1 !== 1'b0) begin
      $display("FAIL sat_counts vc=%0d ec=%0d pass=%b want 3 3 0", vc1, ec1, pass1); bad++;
    end
    total++;
    if (ffv1 !== 1'b1 || ffvec1 !== 5'b00000) begin
      $display("FAIL sat_first ffv=%b vec=%b want 1 00000", ffv1, ffvec1); bad++;
    end
    total++;
  endtask

  task automatic test_abort();
    pulse_start0();
    for (int i = 0; i < 3; i++) send0(sweep_v[i], wrong_y[i]);
    @(negedge clk); #2;
    rst = 1'b1;
    #1;
    if (busy0 !== 1'b0 || if0.vec_ready !== 1'b0 || vc0 !== 16'd0 || ec0 !== 16'd0 || ffv0 !== 1'b0) begin
      $display("FAIL abort_reset busy=%b rdy=%b vc=%0d ec=%0d ffv=%b want all 0",
               busy0, if0.vec_ready, vc0, ec0, ffv0); bad++;
    end
    total++;
    @(negedge clk); rst = 1'b0;
    pulse_start0();
    for (int i = 0; i < 7; i++) send0(sweep_v[i], clean_y[i]);
    wait_done0("abort");
    if (vc0 !== 16'd7 || ec0 !== 16'd0 || pass0 !== 1'b1) begin
      $display("FAIL abort_rerun vc=%0d ec=%0d pass=%b want 7 0 1", vc0, ec0, pass0); bad++;
    end
    total++;
  endtask

  initial begin
    test_reset();
    test_clean_sweep();
    test_mismatch();
    test_gaps_restart();
    test_saturation();
    test_abort();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
